rf_multiport_sb: RTL and testbench

Parametrised general-purpose register file for the pipelined core. It supports NUM_RD combinational read ports and one write port, with optional same-cycle write-to-read bypass. It also holds a per-register pending-write scoreboard (reserve at issue, release at writeback) so decode can detect hazards. A registered commit-trace channel replaces ad-hoc simulation prints.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_scoreboard.sv | 80 ++++++++
 rtl/rf_multiport_sb.sv | 104 ++++++++++
 tb/tb_rf_multiport_sb.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file and its scoreboard.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Index of the hardwired-zero register.
    localparam int REG_ZERO   = 0;

    // The commit record is sized for the widest supported configuration
    // (DATA_W <= 64, ADDR_W <= 8); narrower cores zero-extend into it.
    localparam int REC_ADDR_W = 8;
    localparam int REC_DATA_W = 64;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_DATA_W-1:0] data;
        logic [31:0]           pc;
    } commit_rec_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: reserve at issue, release at writeback.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    input  logic                     flush,
    output logic                     sb_err
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DEPTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        sb_err_q, sb_err_d;
    logic                        rel_en, rsv_hit_rel, rsv_do;

    // A write to a non-zero register is the release of one reservation.
    assign rel_en      = we && (wa != ADDR_W'(REG_ZERO));
    assign rsv_hit_rel = rel_en && (wa == rsv_addr);

    // A full counter can still accept a reserve if it is being released now.
    assign rsv_ok = !rsv_en || (rsv_addr == ADDR_W'(REG_ZERO)) ||
                    (cnt_q[rsv_addr] != CNT_MAX) || rsv_hit_rel;
    assign rsv_do = rsv_en && rsv_ok && (rsv_addr != ADDR_W'(REG_ZERO));

    // Counter next state: flush wins, reserve+release nets to zero, floor at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if ((rsv_do && rsv_addr == ADDR_W'(i)) && !(rel_en && wa == ADDR_W'(i)))
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                else if (!(rsv_do && rsv_addr == ADDR_W'(i)) && (rel_en && wa == ADDR_W'(i)) &&
                         (cnt_q[i] != '0))
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // An untracked write (release with nothing pending) latches the error.
    assign sb_err_d = sb_err_q | (rel_en && (cnt_q[wa] == '0));

    // Counter array and sticky error register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    // Busy lookup; with bypass a last pending write landing now clears the hazard.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] ra;
        logic              wr_hit;
        assign ra     = rd_addr[k*ADDR_W +: ADDR_W];
        assign wr_hit = (BYPASS != 0) && rel_en && (wa == ra) && (cnt_q[ra] == CNT_W'(1));
        assign rd_busy[k] = (ra != ADDR_W'(REG_ZERO)) && (cnt_q[ra] != '0) && !wr_hit;
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport GPR file with write bypass, pending-write scoreboard and commit trace.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [31:0]              wpc,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    input  logic                     flush,
    output logic                     commit_valid,
    output logic [ADDR_W-1:0]        commit_addr,
    output logic [DATA_W-1:0]        commit_data,
    output logic [31:0]              commit_pc,
    output logic                     sb_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] rf_q, rf_d;
    commit_rec_t                  commit_q, commit_d;
    logic                         commit_vld_q;
    logic                         wr_en;

    assign wr_en = we && (wa != ADDR_W'(REG_ZERO));

    // Data array next state; entry 0 is never written so it stays zero.
    always_comb begin
        rf_d = rf_q;
        if (wr_en)
            rf_d[wa] = wd;
    end

    // Combinational read ports with optional same-cycle write forwarding.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = rf_q[rd_addr[k*ADDR_W +: ADDR_W]];
            if ((BYPASS != 0) && wr_en && (wa == rd_addr[k*ADDR_W +: ADDR_W]))
                rd_data[k*DATA_W +: DATA_W] = wd;
        end
    end

    // Trace record captures each effective write and holds otherwise.
    always_comb begin
        commit_d = commit_q;
        if (wr_en) begin
            commit_d.addr = REC_ADDR_W'(wa);
            commit_d.data = REC_DATA_W'(wd);
            commit_d.pc   = wpc;
        end
    end

    // Data array and commit-trace registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_q         <= '0;
            commit_q     <= '0;
            commit_vld_q <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            commit_q     <= commit_d;
            commit_vld_q <= wr_en;
        end
    end

    assign commit_valid = commit_vld_q;
    assign commit_addr  = commit_q.addr[ADDR_W-1:0];
    assign commit_data  = commit_q.data[DATA_W-1:0];
    assign commit_pc    = commit_q.pc;

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .we       (we),
        .wa       (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .flush    (flush),
        .sb_err   (sb_err)
    );

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Bench for rf_multiport_sb: bypass and non-bypass instances share stimulus.
module tb_rf_multiport_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int CW = 2;

    logic            clk, reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rdd_b, rdd_n;
    logic [NR-1:0]    bsy_b, bsy_n;
    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic [31:0]     wpc;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            ok_b, ok_n;
    logic            flush;
    logic            cv_b, cv_n;
    logic [AW-1:0]   ca_b, ca_n;
    logic [DW-1:0]   cd_b, cd_n;
    logic [31:0]     cp_b, cp_n;
    logic            err_b, err_n;

    int total = 0;
    int bad   = 0;

    // reference state
    logic [31:0] m_rf [32];
    int          m_cnt [32];
    bit          m_err;
    bit          m_cv;
    logic [4:0]  m_ca;
    logic [31:0] m_cd, m_cp;

    rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .CNT_W(CW)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(bsy_b),
        .we(we), .wa(wa), .wd(wd), .wpc(wpc), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(ok_b), .flush(flush), .commit_valid(cv_b), .commit_addr(ca_b),
        .commit_data(cd_b), .commit_pc(cp_b), .sb_err(err_b));

    rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .CNT_W(CW)) dut_n (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdd_n), .rd_busy(bsy_n),
        .we(we), .wa(wa), .wd(wd), .wpc(wpc), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(ok_n), .flush(flush), .commit_valid(cv_n), .commit_addr(ca_n),
        .commit_data(cd_n), .commit_pc(cp_n), .sb_err(err_n));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && we && wa == a && m_cnt[a] == 1) return 1'b0;
        return m_cnt[a] != 0;
    endfunction

    function automatic bit exp_ok();
        return !rsv_en || rsv_addr == 0 || m_cnt[rsv_addr] != (2**CW - 1) ||
               (we && wa != 0 && wa == rsv_addr);
    endfunction

    // advance one clock, updating the reference from the inputs held this cycle
    task automatic tick();
        int nc [32];
        bit wr, ok, rsv, ne;
        nc  = m_cnt;
        wr  = we && wa != 0;
        ok  = exp_ok();
        rsv = rsv_en && ok && rsv_addr != 0;
        ne  = m_err | (wr && m_cnt[wa] == 0);
        if (flush) begin
            for (int i = 0; i < 32; i++) nc[i] = 0;
        end else begin
            if (rsv) nc[rsv_addr] = nc[rsv_addr] + 1;
            if (wr) begin
                if (rsv && rsv_addr == wa) nc[wa] = m_cnt[wa];
                else if (m_cnt[wa] > 0) nc[wa] = m_cnt[wa] - 1;
            end
        end
        @(posedge clk);
        m_cnt = nc;
        m_err = ne;
        m_cv  = wr;
        if (wr) begin
            m_rf[wa] = wd;
            m_ca = wa; m_cd = wd; m_cp = wpc;
        end
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_ra(input int k, input logic [4:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_cnt[i] = 0; end
        m_err = 0; m_cv = 0; m_ca = '0; m_cd = '0; m_cp = '0;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        for (int i = 0; i < 32; i++) begin
            set_ra(0, 5'(i)); set_ra(1, 5'(31 - i));
            #1;
            total++;
            if (rdd_b !== '0 || rdd_n !== '0) begin
                bad++; $display("FAIL reset_rd idx=%0d got b=%h n=%h want 0", i, rdd_b, rdd_n);
            end
            total++;
            if (bsy_b !== '0 || bsy_n !== '0) begin
                bad++; $display("FAIL reset_busy idx=%0d got b=%b n=%b want 0", i, bsy_b, bsy_n);
            end
        end
        total++;
        if (cv_b !== 1'b0 || ca_b !== '0 || cd_b !== '0 || cp_b !== '0 || err_b !== 1'b0) begin
            bad++; $display("FAIL reset_trace got v=%b a=%h d=%h pc=%h err=%b want all 0",
                            cv_b, ca_b, cd_b, cp_b, err_b);
        end
        we = 1; wa = 5; wd = 32'h1234_5678; wpc = 32'h40;
        tick();
        idle(); set_ra(0, 5);
        #1;
        total++;
        if (rdd_b[0 +: DW] !== 32'h1234_5678) begin
            bad++; $display("FAIL x5_written got %h want 12345678", rdd_b[0 +: DW]);
        end
        // a write is pending when reset pulses; it must not land
        we = 1; wa = 5; wd = 32'hCAFE_0001;
        #1;
        do_reset();
        idle();
        #1;
        total++;
        if (rdd_b[0 +: DW] !== 32'h0 || rdd_n[0 +: DW] !== 32'h0 || cv_b !== 1'b0) begin
            bad++; $display("FAIL x5_after_reset got b=%h n=%h cv=%b want 0",
                            rdd_b[0 +: DW], rdd_n[0 +: DW], cv_b);
        end
        tick();
        total++;
        if (rdd_n[0 +: DW] !== 32'h0) begin
            bad++; $display("FAIL x5_stays_zero got %h want 0", rdd_n[0 +: DW]);
        end
    endtask

    task automatic test_write_bypass();
        do_reset(); idle();
        we = 1; wa = 3; wd = 32'h11; wpc = 32'h80;
        tick();
        we = 1; wa = 3; wd = 32'hDEAD_BEEF; wpc = 32'h100; set_ra(0, 3);
        #1;
        total++;
        if (rdd_b[0 +: DW] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL bypass_rd got %h want deadbeef", rdd_b[0 +: DW]);
        end
        total++;
        if (rdd_n[0 +: DW] !== 32'h11) begin
            bad++; $display("FAIL nobypass_old got %h want 11", rdd_n[0 +: DW]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rdd_n[0 +: DW] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL nobypass_new got %h want deadbeef", rdd_n[0 +: DW]);
        end
        total++;
        if (cv_b !== 1'b1 || ca_b !== 5'd3 || cd_b !== 32'hDEAD_BEEF || cp_b !== 32'h100) begin
            bad++; $display("FAIL commit got v=%b a=%0d d=%h pc=%h want 1 3 deadbeef 100",
                            cv_b, ca_b, cd_b, cp_b);
        end
        tick();
        total++;
        if (cv_b !== 1'b0 || ca_b !== 5'd3 || cd_b !== 32'hDEAD_BEEF || cp_b !== 32'h100) begin
            bad++; $display("FAIL commit_hold got v=%b a=%0d d=%h pc=%h want 0 3 deadbeef 100",
                            cv_b, ca_b, cd_b, cp_b);
        end
    endtask

    task automatic test_x0();
        idle();
        we = 1; wa = 0; wd = 32'hFFFF_FFFF; wpc = 32'h200; set_ra(0, 0);
        #1;
        total++;
        if (rdd_b[0 +: DW] !== 32'h0 || rdd_n[0 +: DW] !== 32'h0) begin
            bad++; $display("FAIL x0_bypass got b=%h n=%h want 0", rdd_b[0 +: DW], rdd_n[0 +: DW]);
        end
        tick();
        idle();
        #1;
        total++;
        if (cv_b !== 1'b0 || rdd_b[0 +: DW] !== 32'h0) begin
            bad++; $display("FAIL x0_write got cv=%b rd=%h want 0 0", cv_b, rdd_b[0 +: DW]);
        end
        rsv_en = 1; rsv_addr = 0; set_ra(1, 0);
        #1;
        total++;
        if (ok_b !== 1'b1 || bsy_b[1] !== 1'b0) begin
            bad++; $display("FAIL x0_rsv got ok=%b busy=%b want 1 0", ok_b, bsy_b[1]);
        end
        tick();
        idle();
        #1;
        total++;
        if (bsy_b[1] !== 1'b0 || bsy_n[1] !== 1'b0) begin
            bad++; $display("FAIL x0_busy got b=%b n=%b want 0", bsy_b[1], bsy_n[1]);
        end
    endtask

    task automatic test_saturate();
        do_reset(); idle();
        set_ra(0, 7);
        for (int r = 0; r < 3; r++) begin
            rsv_en = 1; rsv_addr = 7;
            #1;
            total++;
            if (ok_b !== 1'b1) begin
                bad++; $display("FAIL rsv_accept n=%0d got %b want 1", r, ok_b);
            end
            tick();
        end
        #1;
        total++;
        if (ok_b !== 1'b0 || ok_n !== 1'b0) begin
            bad++; $display("FAIL rsv_full got b=%b n=%b want 0", ok_b, ok_n);
        end
        tick();
        idle();
        #1;
        total++;
        if (bsy_b[0] !== 1'b1) begin
            bad++; $display("FAIL busy_full got %b want 1", bsy_b[0]);
        end
        for (int w = 0; w < 3; w++) begin
            we = 1; wa = 7; wd = 32'(w + 1); wpc = 32'h300 + 32'(w);
            #1;
            total++;
            if (w < 2) begin
                if (bsy_b[0] !== 1'b1 || bsy_n[0] !== 1'b1) begin
                    bad++; $display("FAIL busy_drain n=%0d got b=%b n=%b want 1", w, bsy_b[0], bsy_n[0]);
                end
            end else begin
                if (bsy_b[0] !== 1'b0 || bsy_n[0] !== 1'b1) begin
                    bad++; $display("FAIL busy_last got b=%b n=%b want 0 1", bsy_b[0], bsy_n[0]);
                end
            end
            tick();
        end
        idle();
        #1;
        total++;
        if (bsy_b[0] !== 1'b0 || bsy_n[0] !== 1'b0 || err_b !== 1'b0) begin
            bad++; $display("FAIL busy_clear got b=%b n=%b err=%b want 0 0 0", bsy_b[0], bsy_n[0], err_b);
        end
    endtask

    task automatic test_same_cycle();
        do_reset(); idle();
        rsv_en = 1; rsv_addr = 9;
        tick();
        rsv_en = 1; rsv_addr = 9; we = 1; wa = 9; wd = 32'h99; wpc = 32'h400;
        #1;
        total++;
        if (ok_b !== 1'b1) begin
            bad++; $display("FAIL same_ok got %b want 1", ok_b);
        end
        tick();
        idle(); set_ra(0, 9);
        #1;
        total++;
        if (bsy_b[0] !== 1'b1 || bsy_n[0] !== 1'b1) begin
            bad++; $display("FAIL same_net0 got b=%b n=%b want 1", bsy_b[0], bsy_n[0]);
        end
        flush = 1; rsv_en = 1; rsv_addr = 9;
        tick();
        idle();
        #1;
        total++;
        if (bsy_b[0] !== 1'b0 || bsy_n[0] !== 1'b0 || err_b !== 1'b0) begin
            bad++; $display("FAIL flush got b=%b n=%b err=%b want 0 0 0", bsy_b[0], bsy_n[0], err_b);
        end
    endtask

    task automatic test_sberr();
        do_reset(); idle();
        we = 1; wa = 4; wd = 32'h42; wpc = 32'h500;
        tick();
        idle(); set_ra(1, 4);
        #1;
        total++;
        if (err_b !== 1'b1 || rdd_b[DW +: DW] !== 32'h42) begin
            bad++; $display("FAIL sberr_set got err=%b rd=%h want 1 42", err_b, rdd_b[DW +: DW]);
        end
        tick();
        flush = 1;
        tick();
        idle();
        tick();
        total++;
        if (err_b !== 1'b1 || err_n !== 1'b1) begin
            bad++; $display("FAIL sberr_sticky got b=%b n=%b want 1", err_b, err_n);
        end
        do_reset();
        total++;
        if (err_b !== 1'b0) begin
            bad++; $display("FAIL sberr_reset got %b want 0", err_b);
        end
    endtask

    task automatic test_random();
        logic [4:0] a;
        do_reset(); idle();
        for (int n = 0; n < 400; n++) begin
            we       = ($urandom_range(0, 99) < 45);
            wa       = 5'($urandom_range(0, 7));
            wd       = $urandom;
            wpc      = $urandom;
            rsv_en   = ($urandom_range(0, 99) < 55);
            rsv_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 99) < 4);
            for (int k = 0; k < NR; k++)
                set_ra(k, 5'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)));
            #1;
            total++;
            if (ok_b !== exp_ok() || ok_n !== exp_ok()) begin
                bad++; $display("FAIL rnd_ok cyc=%0d got b=%b n=%b want %b", n, ok_b, ok_n, exp_ok());
            end
            for (int k = 0; k < NR; k++) begin
                a = rd_addr[k*AW +: AW];
                total++;
                if (rdd_b[k*DW +: DW] !== exp_rd(a, 1) || rdd_n[k*DW +: DW] !== exp_rd(a, 0)) begin
                    bad++; $display("FAIL rnd_rd cyc=%0d port=%0d got b=%h n=%h want %h %h", n, k,
                                    rdd_b[k*DW +: DW], rdd_n[k*DW +: DW], exp_rd(a, 1), exp_rd(a, 0));
                end
                total++;
                if (bsy_b[k] !== exp_busy(a, 1) || bsy_n[k] !== exp_busy(a, 0)) begin
                    bad++; $display("FAIL rnd_busy cyc=%0d port=%0d got b=%b n=%b want %b %b", n, k,
                                    bsy_b[k], bsy_n[k], exp_busy(a, 1), exp_busy(a, 0));
                end
            end
            tick();
            total++;
            if (cv_b !== m_cv || ca_b !== m_ca || cd_b !== m_cd || cp_b !== m_cp) begin
                bad++; $display("FAIL rnd_commit cyc=%0d got %b %h %h %h want %b %h %h %h", n,
                                cv_b, ca_b, cd_b, cp_b, m_cv, m_ca, m_cd, m_cp);
            end
            total++;
            if (err_b !== m_err || err_n !== m_err) begin
                bad++; $display("FAIL rnd_err cyc=%0d got b=%b n=%b want %b", n, err_b, err_n, m_err);
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b0; rd_addr = '0; we = 0; wa = '0; wd = '0; wpc = '0;
        rsv_en = 0; rsv_addr = '0; flush = 0;
        #2;
        test_reset();
        test_write_bypass();
        test_x0();
        test_saturate();
        test_same_cycle();
        test_sberr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
